// File: rtl/acc32_seq.sv
// acc32_seq: valid/ready stream accumulator around one adder32, counts carry-outs and beats per packet.
// Latency: result valid the cycle after the in_last beat is accepted; one beat per cycle inside a packet.
// Backpressure: in_ready drops while a result waits for out_ready; one bubble cycle between packets.
// Optional feature macro: ACC32_SAT_EN (sticky sum saturation on any carry-out).

// 32-bit ripple-style adder with carry-in and carry-out
module adder32 (
    input  logic [32:1] A,
    input  logic [32:1] B,
    input  logic        c0,
    output logic [32:1] S,
    output logic        c32
);
    assign {c32, S} = {1'b0, A} + {1'b0, B} + {32'd0, c0};
endmodule

module acc32_seq #(
    parameter int CW = 8,
    parameter int NW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [32:1]   in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [32:1]   out_sum,
    output logic [CW-1:0] out_carry,
    output logic [NW-1:0] out_count
);
    typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_DONE} state_t;

    localparam logic [CW-1:0] CMAX = '1;
    localparam logic [NW-1:0] NMAX = '1;

    state_t        state_q, state_d;
    logic [32:1]   acc_q, acc_d;
    logic [CW-1:0] carry_cnt_q, carry_cnt_d;
    logic [NW-1:0] beat_cnt_q, beat_cnt_d;
    logic [32:1]   out_sum_q, out_sum_d;
    logic [CW-1:0] out_carry_q, out_carry_d;
    logic [NW-1:0] out_count_q, out_count_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;

    logic [32:1]   add_a;
    logic [32:1]   add_s;
    logic          add_c32;
    logic          accept;
    logic [CW-1:0] carry_base, carry_nxt;
    logic [NW-1:0] beat_base, beat_nxt;
    logic [32:1]   sum_nxt;

`ifdef ACC32_SAT_EN
    logic sat_q, sat_d;
    logic sat_nxt;
`endif

    // The first beat of a packet adds to zero so stale acc never leaks in
    assign add_a = (state_q == ST_IDLE) ? 32'd0 : acc_q;

    adder32 u_adder (
        .A   (add_a),
        .B   (in_data),
        .c0  (1'b0),
        .S   (add_s),
        .c32 (add_c32)
    );

    assign accept    = in_valid && in_ready_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_carry = out_carry_q;
    assign out_count = out_count_q;

    // Saturating counter increments and the next accumulator value for an accepted beat
    always_comb begin
        carry_base = (state_q == ST_IDLE) ? '0 : carry_cnt_q;
        beat_base  = (state_q == ST_IDLE) ? '0 : beat_cnt_q;
        carry_nxt  = (add_c32 && (carry_base != CMAX)) ? carry_base + CW'(1) : carry_base;
        beat_nxt   = (beat_base != NMAX) ? beat_base + NW'(1) : beat_base;
`ifdef ACC32_SAT_EN
        sat_nxt    = ((state_q == ST_IDLE) ? 1'b0 : sat_q) | add_c32;
        sum_nxt    = sat_nxt ? 32'hFFFF_FFFF : add_s;
`else
        sum_nxt    = add_s;
`endif
    end

    // Next-state logic: IDLE/ACC fold beats, DONE holds the result until out_ready
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        carry_cnt_d = carry_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        out_sum_d   = out_sum_q;
        out_carry_d = out_carry_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
`ifdef ACC32_SAT_EN
        sat_d       = sat_q;
`endif
        case (state_q)
            ST_IDLE, ST_ACC: begin
                if (accept) begin
                    acc_d       = sum_nxt;
                    carry_cnt_d = carry_nxt;
                    beat_cnt_d  = beat_nxt;
`ifdef ACC32_SAT_EN
                    sat_d       = sat_nxt;
`endif
                    if (in_last) begin
                        out_sum_d   = sum_nxt;
                        out_carry_d = carry_nxt;
                        out_count_d = beat_nxt;
                        out_valid_d = 1'b1;
                        in_ready_d  = 1'b0;
                        state_d     = ST_DONE;
                    end else begin
                        state_d = ST_ACC;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
`ifdef ACC32_SAT_EN
                    sat_d       = 1'b0;
`endif
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset drops any packet in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            carry_cnt_q <= '0;
            beat_cnt_q  <= '0;
            out_sum_q   <= '0;
            out_carry_q <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef ACC32_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            carry_cnt_q <= carry_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            out_sum_q   <= out_sum_d;
            out_carry_q <= out_carry_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifdef ACC32_SAT_EN
            sat_q       <= sat_d;
`endif
        end
    end
endmodule

// File: tb/tb_acc32_seq.sv
// Directed bench for acc32_seq: default-width instance plus a CW=2/NW=2 instance for counter saturation.
// Both instances share the same stimulus and therefore run in lockstep.
// Inputs change 1 time unit after the rising edge, outputs are sampled at the same point.
module tb_acc32_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [32:1] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid;
    logic [32:1] out_sum;
    logic [7:0]  out_carry;
    logic [15:0] out_count;

    logic        s_in_ready, s_out_valid;
    logic [32:1] s_out_sum;
    logic [1:0]  s_out_carry;
    logic [1:0]  s_out_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    acc32_seq u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry), .out_count(out_count)
    );

    acc32_seq #(.CW(2), .NW(2)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_sum(s_out_sum), .out_carry(s_out_carry), .out_count(s_out_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL send_ready_timeout in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b1;
        in_data  = $urandom;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hDEAD_BEEF;
        in_last = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_sum !== 32'd0) begin n_bad++; $display("FAIL reset_out_sum got=%h exp=0", out_sum); end
        n_cmp++; if (out_carry !== 8'd0) begin n_bad++; $display("FAIL reset_out_carry got=%0d exp=0", out_carry); end
        n_cmp++; if (out_count !== 16'd0) begin n_bad++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
        rst_n = 1'b1;
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_idle_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_beat(32'd1, 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_mid_valid got=%b exp=0", out_valid); end
        send_beat(32'd2, 1'b0);
        send_beat(32'd3, 1'b1);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        n_cmp++; if (out_sum !== 32'd6) begin n_bad++; $display("FAIL basic_sum got=%h exp=6", out_sum); end
        n_cmp++; if (out_carry !== 8'd0) begin n_bad++; $display("FAIL basic_carry got=%0d exp=0", out_carry); end
        n_cmp++; if (out_count !== 16'd3) begin n_bad++; $display("FAIL basic_count got=%0d exp=3", out_count); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_bubble_ready got=%b exp=0", in_ready); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_drop got=%b exp=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready_back got=%b exp=1", in_ready); end
        n_cmp++; if (out_sum !== 32'd6) begin n_bad++; $display("FAIL basic_sum_hold got=%h exp=6", out_sum); end
    endtask

    task automatic test_carry();
        logic [31:0] exp_sum;
`ifdef ACC32_SAT_EN
        exp_sum = 32'hFFFF_FFFF;
`else
        exp_sum = 32'h0000_0000;
`endif
        out_ready = 1'b1;
        send_beat(32'hFFFF_FFFF, 1'b0);
        send_beat(32'd2, 1'b0);
        send_beat(32'hFFFF_FFFF, 1'b1);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL carry_valid got=%b exp=1", out_valid); end
        n_cmp++; if (out_sum !== exp_sum) begin n_bad++; $display("FAIL carry_sum got=%h exp=%h", out_sum, exp_sum); end
        n_cmp++; if (out_carry !== 8'd2) begin n_bad++; $display("FAIL carry_carry got=%0d exp=2", out_carry); end
        n_cmp++; if (out_count !== 16'd3) begin n_bad++; $display("FAIL carry_count got=%0d exp=3", out_count); end
        step();
    endtask

    task automatic test_single_hold();
        out_ready = 1'b0;
        send_beat(32'h1234_5678, 1'b1);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid[%0d] got=%b exp=1", i, out_valid); end
            n_cmp++; if (out_sum !== 32'h1234_5678) begin n_bad++; $display("FAIL hold_sum[%0d] got=%h exp=12345678", i, out_sum); end
            n_cmp++; if (out_count !== 16'd1) begin n_bad++; $display("FAIL hold_count[%0d] got=%0d exp=1", i, out_count); end
            n_cmp++; if (out_carry !== 8'd0) begin n_bad++; $display("FAIL hold_carry[%0d] got=%0d exp=0", i, out_carry); end
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL hold_in_ready[%0d] got=%b exp=0", i, in_ready); end
            in_valid = 1'b1;
            in_data  = 32'hAAAA_0000 + 32'(i);
            step();
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL hold_release got=%b exp=0", out_valid); end
        n_cmp++; if (out_sum !== 32'h1234_5678) begin n_bad++; $display("FAIL hold_sum_after got=%h exp=12345678", out_sum); end
    endtask

    task automatic test_saturation();
        logic [31:0] exp_a, exp_b;
`ifdef ACC32_SAT_EN
        exp_a = 32'hFFFF_FFFF;
        exp_b = 32'hFFFF_FFFF;
`else
        exp_a = 32'h8000_0000;
        exp_b = 32'hFFFF_FFFB;
`endif
        out_ready = 1'b1;
        // 5 x 8000_0000: carries on beats 2 and 4 only
        for (int i = 0; i < 5; i++) send_beat(32'h8000_0000, (i == 4));
        n_cmp++; if (out_sum !== exp_a) begin n_bad++; $display("FAIL sat80_sum got=%h exp=%h", out_sum, exp_a); end
        n_cmp++; if (out_carry !== 8'd2) begin n_bad++; $display("FAIL sat80_carry got=%0d exp=2", out_carry); end
        n_cmp++; if (s_out_carry !== 2'd2) begin n_bad++; $display("FAIL sat80_small_carry got=%0d exp=2", s_out_carry); end
        n_cmp++; if (s_out_count !== 2'd3) begin n_bad++; $display("FAIL sat80_small_count got=%0d exp=3", s_out_count); end
        step();
        // 5 x FFFF_FFFF: carries on beats 2..5
        for (int i = 0; i < 5; i++) send_beat(32'hFFFF_FFFF, (i == 4));
        n_cmp++; if (out_sum !== exp_b) begin n_bad++; $display("FAIL satff_sum got=%h exp=%h", out_sum, exp_b); end
        n_cmp++; if (out_carry !== 8'd4) begin n_bad++; $display("FAIL satff_carry got=%0d exp=4", out_carry); end
        n_cmp++; if (out_count !== 16'd5) begin n_bad++; $display("FAIL satff_count got=%0d exp=5", out_count); end
        n_cmp++; if (s_out_carry !== 2'd3) begin n_bad++; $display("FAIL satff_small_carry got=%0d exp=3", s_out_carry); end
        n_cmp++; if (s_out_count !== 2'd3) begin n_bad++; $display("FAIL satff_small_count got=%0d exp=3", s_out_count); end
        n_cmp++; if (s_out_sum !== exp_b) begin n_bad++; $display("FAIL satff_small_sum got=%h exp=%h", s_out_sum, exp_b); end
        step();
    endtask

    task automatic test_abort();
        out_ready = 1'b1;
        send_beat(32'd100, 1'b0);
        send_beat(32'd200, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_no_result got=%b exp=0", out_valid); end
        n_cmp++; if (out_sum !== 32'd0) begin n_bad++; $display("FAIL abort_sum_cleared got=%h exp=0", out_sum); end
        send_beat(32'd7, 1'b1);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL abort_fresh_valid got=%b exp=1", out_valid); end
        n_cmp++; if (out_sum !== 32'd7) begin n_bad++; $display("FAIL abort_fresh_sum got=%h exp=7", out_sum); end
        n_cmp++; if (out_count !== 16'd1) begin n_bad++; $display("FAIL abort_fresh_count got=%0d exp=1", out_count); end
        step();
    endtask

    task automatic test_gaps();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            while ($urandom_range(0, 1) == 1) step();
            send_beat(32'd1, (i == 19));
        end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL gaps_valid got=%b exp=1", out_valid); end
        n_cmp++; if (out_sum !== 32'd20) begin n_bad++; $display("FAIL gaps_sum got=%0d exp=20", out_sum); end
        n_cmp++; if (out_count !== 16'd20) begin n_bad++; $display("FAIL gaps_count got=%0d exp=20", out_count); end
        n_cmp++; if (out_carry !== 8'd0) begin n_bad++; $display("FAIL gaps_carry got=%0d exp=0", out_carry); end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send_beat(32'd5, 1'b1);
        n_cmp++; if (out_sum !== 32'd5) begin n_bad++; $display("FAIL b2b_first_sum got=%0d exp=5", out_sum); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_bubble got=%b exp=0", in_ready); end
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_after got=%b exp=1", in_ready); end
        send_beat(32'd9, 1'b1);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_second_valid got=%b exp=1", out_valid); end
        n_cmp++; if (out_sum !== 32'd9) begin n_bad++; $display("FAIL b2b_second_sum got=%0d exp=9", out_sum); end
        n_cmp++; if (out_count !== 16'd1) begin n_bad++; $display("FAIL b2b_second_count got=%0d exp=1", out_count); end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_single_hold();
        test_saturation();
        test_abort();
        test_gaps();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
